de1_soc_switch_debounce: RTL and testbench

Conditions the raw DE1-SoC slide-switch pins before they reach the switches PIO `in_port`. Each bit gets a 2-flop synchroniser and an independent debounce counter. The block produces a clean, glitch-free level vector plus one-cycle change pulses. The PIO's level IRQ (`|(in & mask)`) therefore never sees metastable values or contact bounce.

---
 rtl/de1_soc_switch_debounce.sv | 90 +++++++++
 tb/tb_de1_soc_switch_debounce.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/de1_soc_switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : de1_soc_switch_debounce                                       |
// | Purpose  : Conditions raw DE1-SoC slide-switch pins for the switches     |
// |            PIO. Each bit passes through a 2-flop synchroniser and an     |
// |            independent debounce counter, giving a glitch-free level      |
// |            vector plus one-cycle change pulses.                          |
// | Ports    : clk         - system clock, rising edge                       |
// |            reset_n     - asynchronous assert, active-low reset           |
// |            sw_raw      - asynchronous switch pins [WIDTH]                |
// |            sw_stable   - debounced level, drives PIO in_port [WIDTH]     |
// |            sw_changed  - one-cycle pulse per bit on level update [WIDTH] |
// |            any_changed - OR of sw_changed, coincident with it            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module de1_soc_switch_debounce #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_changed,
   output logic             any_changed
);

   // Terminal count: a mismatch seen while the counter already holds this
   // value is the DEBOUNCE_CYCLES-th consecutive one, so the new level is
   // accepted on that edge.
   localparam logic [CNT_WIDTH-1:0] c_cnt_max = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] w_stable_nxt;
   logic [WIDTH-1:0] w_changed_nxt;

   // Two-flop synchroniser; only r_sync2 is consumed downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CNT_WIDTH-1:0] r_cnt;
      logic                 w_mismatch;
      logic                 w_expire;

      assign w_mismatch = r_sync2[i] ^ sw_stable[i];
      assign w_expire   = w_mismatch && (r_cnt == c_cnt_max);

      // Any agreeing cycle clears the count, so bounce shorter than the
      // debounce window can never accumulate. Clearing on expiry keeps the
      // count bounded by c_cnt_max and prevents wrap-around.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
         end else if (!w_mismatch || w_expire) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_stable_nxt[i]  = w_expire ? r_sync2[i] : sw_stable[i];
      assign w_changed_nxt[i] = w_expire;
   end

   // All outputs come straight from flops; any_changed is formed from the
   // next-state pulse vector so it lines up with sw_changed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_stable   <= '0;
         sw_changed  <= '0;
         any_changed <= 1'b0;
      end else begin
         sw_stable   <= w_stable_nxt;
         sw_changed  <= w_changed_nxt;
         any_changed <= |w_changed_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_de1_soc_switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_de1_soc_switch_debounce                                    |
// | Purpose  : Self-checking bench for de1_soc_switch_debounce with          |
// |            DEBOUNCE_CYCLES=4, WIDTH=10. Directed scenarios followed by   |
// |            randomized switch activity, checked against a timestamp-based |
// |            reference model of the debounce rules.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_de1_soc_switch_debounce;

   localparam int W = 10;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_changed;
   logic         any_changed;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: synchroniser as a two-stage shift, debounce as
   // "has the synchronised level disagreed with the accepted level on every
   // edge since the last agreement, for at least D edges?"
   logic [W-1:0] m_sync1, m_sync2, m_stable, m_changed;
   logic         m_any;
   int           last_agree [W];
   int           edge_n = 0;
   string        phase = "reset";

   de1_soc_switch_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .CNT_WIDTH       (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw_raw      (sw_raw),
      .sw_stable   (sw_stable),
      .sw_changed  (sw_changed),
      .any_changed (any_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %0s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_sync1   = '0;
      m_sync2   = '0;
      m_stable  = '0;
      m_changed = '0;
      m_any     = 1'b0;
      for (int i = 0; i < W; i++) last_agree[i] = edge_n;
   endtask

   task automatic compare_all();
      check({phase, "_stable"},  32'(sw_stable),   32'(m_stable));
      check({phase, "_changed"}, 32'(sw_changed),  32'(m_changed));
      check({phase, "_any"},     32'(any_changed), 32'(m_any));
   endtask

   // Advance one clock edge, update the model, then sample 1 ns later.
   task automatic step();
      logic [W-1:0] nst;
      logic [W-1:0] nch;
      @(posedge clk);
      edge_n++;
      if (!reset_n) begin
         model_clear();
      end else begin
         nst = m_stable;
         nch = '0;
         for (int i = 0; i < W; i++) begin
            if (m_sync2[i] == m_stable[i]) begin
               last_agree[i] = edge_n;
            end else if (edge_n - last_agree[i] >= D) begin
               nst[i]        = m_sync2[i];
               nch[i]        = 1'b1;
               last_agree[i] = edge_n;
            end
         end
         m_stable  = nst;
         m_changed = nch;
         m_any     = |nch;
         m_sync2   = m_sync1;
         m_sync1   = sw_raw;
      end
      #1;
      compare_all();
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_clear();
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int pulses;
      int anyp;

      // 1. Reset / power-up with switches low
      reset_n = 1'b0;
      sw_raw  = '0;
      #1;
      model_clear();
      compare_all();
      check("reset_stable_const", 32'(sw_stable), 32'h0);
      steps(3);
      reset_n = 1'b1;
      phase = "idle";
      anyp = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         anyp += int'(any_changed);
      end
      check("idle_stable_const", 32'(sw_stable), 32'h0);
      check("idle_any_pulses", 32'(anyp), 32'd0);

      // 2. Clean step on bit 0
      phase = "step";
      sw_raw = 10'h001;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e == 5) check("step_before_edge6", 32'(sw_stable), 32'h000);
      end
      check("step_stable_edge6",  32'(sw_stable),   32'h001);
      check("step_changed_edge6", 32'(sw_changed),  32'h001);
      check("step_any_edge6",     32'(any_changed), 32'h1);
      step();
      check("step_changed_after", 32'(sw_changed),  32'h000);
      check("step_any_after",     32'(any_changed), 32'h0);

      // 3. Bounce on bit 3: high 3, low 1, high 3, low 1, then hold high
      phase = "bounce";
      pulses = 0;
      for (int r = 0; r < 2; r++) begin
         sw_raw[3] = 1'b1;
         for (int k = 0; k < 3; k++) begin step(); pulses += int'(sw_changed[3]); end
         sw_raw[3] = 1'b0;
         step();
         pulses += int'(sw_changed[3]);
      end
      for (int k = 0; k < 3; k++) begin step(); pulses += int'(sw_changed[3]); end
      check("bounce_no_early", 32'(sw_stable[3]), 32'h0);
      sw_raw[3] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         pulses += int'(sw_changed[3]);
         if (e == 5) check("bounce_before_edge6", 32'(sw_stable[3]), 32'h0);
      end
      check("bounce_rise_edge6", 32'(sw_stable[3]), 32'h1);
      steps(6);
      check("bounce_pulse_count", 32'(pulses), 32'd1);

      // 4. All bits together 000 -> 3FF
      phase = "multi";
      sw_raw = 10'h000;
      steps(12);
      check("multi_settle_low", 32'(sw_stable), 32'h000);
      sw_raw = 10'h3FF;
      anyp = 0;
      for (int e = 1; e <= 6; e++) begin step(); anyp += int'(any_changed); end
      check("multi_stable",  32'(sw_stable),  32'h3FF);
      check("multi_changed", 32'(sw_changed), 32'h3FF);
      for (int k = 0; k < 10; k++) begin step(); anyp += int'(any_changed); end
      check("multi_any_pulses", 32'(anyp), 32'd1);

      // 5. Reset in the middle of a qualification
      phase = "midrst";
      sw_raw = 10'h000;
      steps(12);
      sw_raw[0] = 1'b1;
      steps(4);
      async_reset();
      check("midrst_stable_clear",  32'(sw_stable),   32'h0);
      check("midrst_changed_clear", 32'(sw_changed),  32'h0);
      check("midrst_any_clear",     32'(any_changed), 32'h0);
      steps(3);
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e == 5) check("midrst_before_edge6", 32'(sw_stable[0]), 32'h0);
      end
      check("midrst_rise_edge6", 32'(sw_stable[0]), 32'h1);

      // 6. Power-up with a mixed switch pattern already high
      phase = "pwrhi";
      async_reset();
      sw_raw = 10'h2A5;
      steps(3);
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e == 5) check("pwrhi_before_edge6", 32'(sw_stable), 32'h000);
      end
      check("pwrhi_stable",  32'(sw_stable),  32'h2A5);
      check("pwrhi_changed", 32'(sw_changed), 32'h2A5);
      step();
      check("pwrhi_changed_after", 32'(sw_changed), 32'h000);

      // Randomized activity: occasional flips, bursts of bounce, rare resets
      phase = "rand";
      for (int k = 0; k < 1500; k++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 8) begin
            sw_raw[$urandom_range(0, W-1)] ^= 1'b1;
         end else if (sel < 10) begin
            sw_raw = W'($urandom);
         end else if (sel == 10) begin
            async_reset();
            steps(int'($urandom_range(1, 3)));
            reset_n = 1'b1;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
